mpu_timer_bank: RTL and testbench
=================================

# mpu_timer_bank

Parametrised millisecond timer bank for the MPU: one shared prescaler turns `clk_sys` into a millisecond tick, and N independent channels count those ticks down to programmable deadlines. Each channel runs in one-shot or periodic mode and raises a sticky, individually acknowledged interrupt. It replaces the single-compare millisecond timer and supplies the MPU with its free-running ms and cycle counters plus its timer interrupts.

## Interface
- `N_CH`, default 4: number of timer channels, 1..16.
- `CNT_W`, default 32: width of all counters, compares and the frequency input.
- `CH_W`, default `$clog2(N_CH)` with a minimum of 1: channel index width.

Ports:
- `clk_sys`  in  1  system clock.
- `millisecond_counter_reset`  in  1  reset, asynchronous, active-high.
- `sysclk_frequency`  in  CNT_W  tick period minus 1, in clk_sys cycles.
- `wr_en`  in  1  channel configuration write strobe.
- `wr_ch`  in  CH_W  channel index for the write.
- `wr_compare`  in  CNT_W  deadline in ms; 0 disables the channel.
- `wr_periodic`  in  1  1 = periodic, 0 = one-shot.
- `irq_ack`  in  N_CH  per-channel pending clear, one pulse per bit.
- `millisecond_counter`  out  CNT_W  ms ticks since reset; wraps.
- `cycle_counter`  out  CNT_W  clk_sys cycles since reset; wraps.
- `ms_strobe`  out  1  one-cycle pulse per ms tick.
- `ch_remaining`  out  N_CH*CNT_W  per-channel ms left; channel k occupies bits [k*CNT_W +: CNT_W].
- `ch_armed`  out  N_CH  channel is counting.
- `irq_pending`  out  N_CH  sticky per-channel interrupt.
- `irq_any`  out  1  OR of `irq_pending`, registered.

## Operation
- Reset: every output and every internal register is 0, and all channels are disarmed.
- Prescaler: increments every cycle. The tick condition is prescaler >= `sysclk_frequency`. On a tick the prescaler goes to 0 and `millisecond_counter` increments.
  - The >= compare keeps the tick period bounded when `sysclk_frequency` is lowered below the current prescaler value.
- `cycle_counter`: increments every cycle with no condition. It wraps 2^CNT_W-1 → 0.
- Channel write (`wr_en`=1, `wr_ch` < N_CH):
  - Effects: remaining ← `wr_compare`, periodic ← `wr_periodic`, armed ← (`wr_compare` != 0), and that channel's pending bit is cleared.
  - A write with `wr_ch` >= N_CH is ignored.
- Channel on a tick, when armed and not written this cycle:
  - If remaining == 1: pending ← 1. If periodic, remaining ← compare. If one-shot, remaining ← 0 and armed ← 0.
  - Otherwise: remaining ← remaining − 1.
- A disarmed channel ignores ticks.
- Collisions:
  - Write and tick on the same channel in the same cycle: the write wins and no decrement is applied.
  - `irq_ack` and a fire on the same channel in the same cycle: the fire wins and pending stays 1.
  - `irq_ack` on a channel with pending = 0 has no effect.
- Compare value 0 never fires, and writing it disarms the channel.

## Timing
- The tick period is exactly `sysclk_frequency`+1 cycles. `sysclk_frequency`=0 gives a tick every cycle.
- `ms_strobe`, the `millisecond_counter` increment and any channel `irq_pending` set all become visible on the same clock edge.
- `irq_any` lags `irq_pending` by one cycle.
- A channel armed with compare C fires on the C-th tick after the write edge. A tick in the write cycle itself is not counted.
- A periodic channel fires every C ticks with zero drift. Its pending bit stays 1 across fires until acknowledged; there is no overflow count.
- Asserting reset mid-count clears all state immediately, asynchronously. The first tick after release comes `sysclk_frequency`+1 cycles later.

## Structure
- Package `mpu_timer_pkg`: the `CNT_W` default, the channel-mode constants (`MODE_ONESHOT`=0, `MODE_PERIODIC`=1) and the channel state record (remaining, compare, periodic, armed, pending).
- Sub-module `mpu_timer_channel`, instantiated N_CH times with a generate loop.
  - Inputs: tick, write, ack, compare, mode.
  - Outputs: remaining, armed, pending.
- The top level holds the prescaler, the two free-running counters, write decode and `irq_any`.

## Test plan
- `sysclk_frequency`=4, reset released at cycle 0 → `ms_strobe` on cycles 5, 10 and 15, and `millisecond_counter`=3 after cycle 15.
- Channel 0 written periodic with compare 3 at cycle 1 → `irq_pending[0]` rises with the 3rd tick (cycle 15). An ack at cycle 16 clears it, and it rises again at cycle 30.
- Channel 1 written one-shot with compare 2 → fires at the 2nd tick. `ch_armed[1]`=0 afterwards and there is no further fire over 10 ticks.
- `irq_ack[0]` asserted in the same cycle channel 0 fires → `irq_pending[0]` stays 1. Also: a write of compare 0 disarms the channel, and `wr_ch`=N_CH changes nothing.
- `sysclk_frequency` changed from 100 to 3 while the prescaler is at 50 → a tick on the next cycle, then a tick every 4 cycles.
- Reset asserted mid-count with two channels armed → all outputs 0 on the same edge and no interrupt after release until the channels are rewritten.

Source files
------------

// File: rtl/mpu_timer_pkg.sv
// -----------------------------------------------------------------------------
// mpu_timer_pkg
// Shared definitions for the MPU millisecond timer bank.
//   CNT_W_DEFAULT : default width of counters, compares and frequency input
//   MODE_ONESHOT / MODE_PERIODIC : channel mode encodings
//   ch_state_t    : per-channel state record. Counter fields are sized at
//                   CNT_W_DEFAULT; narrower instances zero-extend into them.
// -----------------------------------------------------------------------------
package mpu_timer_pkg;

  localparam int CNT_W_DEFAULT = 32;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] remaining;
    logic [CNT_W_DEFAULT-1:0] compare;
    logic                     periodic;
    logic                     armed;
    logic                     pending;
  } ch_state_t;

endpackage

// File: rtl/mpu_timer_channel.sv
// -----------------------------------------------------------------------------
// mpu_timer_channel
// One countdown channel of the timer bank.
//   clk_sys, millisecond_counter_reset : clock, async active-high reset
//   tick      : shared millisecond tick (one cycle wide)
//   write     : load compare/mode for this channel
//   ack       : clear the sticky pending bit
//   compare   : deadline in ms (0 = disarm)
//   mode      : MODE_ONESHOT / MODE_PERIODIC
//   remaining : ms left until the next fire (0 when disarmed)
//   armed     : channel is counting
//   pending   : sticky interrupt
// -----------------------------------------------------------------------------
module mpu_timer_channel
  import mpu_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_sys,
  input  logic             millisecond_counter_reset,
  input  logic             tick,
  input  logic             write,
  input  logic             ack,
  input  logic [CNT_W-1:0] compare,
  input  logic             mode,
  output logic [CNT_W-1:0] remaining,
  output logic             armed,
  output logic             pending
);

  localparam logic [CNT_W_DEFAULT-1:0] REM_ONE = {{(CNT_W_DEFAULT-1){1'b0}}, 1'b1};

  ch_state_t state_r;

  // Channel state: a write beats a tick, and a fire beats an ack.
  always_ff @(posedge clk_sys or posedge millisecond_counter_reset) begin
    if (millisecond_counter_reset) begin
      state_r <= '0;
    end else if (write) begin
      state_r.remaining <= CNT_W_DEFAULT'(compare);
      state_r.compare   <= CNT_W_DEFAULT'(compare);
      state_r.periodic  <= mode;
      state_r.armed     <= (compare != '0);
      state_r.pending   <= 1'b0;
    end else if (tick && state_r.armed) begin
      if (state_r.remaining == REM_ONE) begin
        state_r.pending <= 1'b1;
        if (state_r.periodic == MODE_PERIODIC) begin
          // Reload rather than wrap so a periodic channel never drifts.
          state_r.remaining <= state_r.compare;
        end else begin
          state_r.remaining <= '0;
          state_r.armed     <= 1'b0;
        end
      end else begin
        state_r.remaining <= state_r.remaining - REM_ONE;
        if (ack) begin
          state_r.pending <= 1'b0;
        end
      end
    end else if (ack) begin
      state_r.pending <= 1'b0;
    end
  end

  assign remaining = state_r.remaining[CNT_W-1:0];
  assign armed     = state_r.armed;
  assign pending   = state_r.pending;

endmodule

// File: rtl/mpu_timer_bank.sv
// -----------------------------------------------------------------------------
// mpu_timer_bank
// Shared millisecond prescaler, free-running ms/cycle counters and N_CH
// countdown channels with sticky, individually acknowledged interrupts.
//   clk_sys, millisecond_counter_reset : clock, async active-high reset
//   sysclk_frequency    : tick period minus 1, in clk_sys cycles
//   wr_en/wr_ch/wr_compare/wr_periodic : channel configuration write
//   irq_ack             : per-channel pending clear
//   millisecond_counter : ms ticks since reset (wraps)
//   cycle_counter       : clk_sys cycles since reset (wraps)
//   ms_strobe           : one-cycle pulse per ms tick
//   ch_remaining        : per-channel ms left, channel k at [k*CNT_W +: CNT_W]
//   ch_armed, irq_pending : per-channel status
//   irq_any             : registered OR of irq_pending
// -----------------------------------------------------------------------------
module mpu_timer_bank
  import mpu_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk_sys,
  input  logic                    millisecond_counter_reset,
  input  logic [CNT_W-1:0]        sysclk_frequency,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [CNT_W-1:0]        wr_compare,
  input  logic                    wr_periodic,
  input  logic [N_CH-1:0]         irq_ack,
  output logic [CNT_W-1:0]        millisecond_counter,
  output logic [CNT_W-1:0]        cycle_counter,
  output logic                    ms_strobe,
  output logic [N_CH*CNT_W-1:0]   ch_remaining,
  output logic [N_CH-1:0]         ch_armed,
  output logic [N_CH-1:0]         irq_pending,
  output logic                    irq_any
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] prescaler_r;
  logic [CNT_W-1:0] millisecond_counter_r;
  logic [CNT_W-1:0] cycle_counter_r;
  logic             ms_strobe_r;
  logic             irq_any_r;
  logic             tick_s;
  logic [N_CH-1:0]  wr_hit_s;
  logic [N_CH-1:0]  pending_s;

  // >= rather than == so lowering the period below the current count
  // produces a tick on the next cycle instead of a full wrap.
  assign tick_s = (prescaler_r >= sysclk_frequency);

  // Prescaler, ms counter and strobe move together on the tick edge.
  always_ff @(posedge clk_sys or posedge millisecond_counter_reset) begin
    if (millisecond_counter_reset) begin
      prescaler_r           <= '0;
      millisecond_counter_r <= '0;
      ms_strobe_r           <= 1'b0;
    end else if (tick_s) begin
      prescaler_r           <= '0;
      millisecond_counter_r <= millisecond_counter_r + CNT_ONE;
      ms_strobe_r           <= 1'b1;
    end else begin
      prescaler_r           <= prescaler_r + CNT_ONE;
      ms_strobe_r           <= 1'b0;
    end
  end

  // Free-running cycle counter and the registered interrupt summary.
  always_ff @(posedge clk_sys or posedge millisecond_counter_reset) begin
    if (millisecond_counter_reset) begin
      cycle_counter_r <= '0;
      irq_any_r       <= 1'b0;
    end else begin
      cycle_counter_r <= cycle_counter_r + CNT_ONE;
      irq_any_r       <= |pending_s;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    // An out-of-range wr_ch matches no channel and is silently dropped.
    assign wr_hit_s[k] = wr_en && (wr_ch == CH_W'(k));

    mpu_timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_sys                   (clk_sys),
      .millisecond_counter_reset (millisecond_counter_reset),
      .tick                      (tick_s),
      .write                     (wr_hit_s[k]),
      .ack                       (irq_ack[k]),
      .compare                   (wr_compare),
      .mode                      (wr_periodic),
      .remaining                 (ch_remaining[k*CNT_W +: CNT_W]),
      .armed                     (ch_armed[k]),
      .pending                   (pending_s[k])
    );
  end

  assign millisecond_counter = millisecond_counter_r;
  assign cycle_counter       = cycle_counter_r;
  assign ms_strobe           = ms_strobe_r;
  assign irq_pending         = pending_s;
  assign irq_any             = irq_any_r;

endmodule

// File: tb/tb_mpu_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_mpu_timer_bank
// Directed and random stimulus against a deadline-based reference model:
// each armed channel holds an absolute ms deadline rather than a countdown.
// -----------------------------------------------------------------------------
module tb_mpu_timer_bank;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk_sys = 1'b0;
  logic           rst;
  logic [W-1:0]   freq;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   wr_compare;
  logic           wr_periodic;
  logic [N-1:0]   irq_ack;
  logic [W-1:0]   ms_cnt;
  logic [W-1:0]   cyc_cnt;
  logic           ms_strobe;
  logic [N*W-1:0] ch_remaining;
  logic [N-1:0]   ch_armed;
  logic [N-1:0]   irq_pending;
  logic           irq_any;

  always #5 clk_sys = ~clk_sys;

  mpu_timer_bank #(.N_CH(N), .CNT_W(W)) dut (
    .clk_sys                   (clk_sys),
    .millisecond_counter_reset (rst),
    .sysclk_frequency          (freq),
    .wr_en                     (wr_en),
    .wr_ch                     (wr_ch),
    .wr_compare                (wr_compare),
    .wr_periodic               (wr_periodic),
    .irq_ack                   (irq_ack),
    .millisecond_counter       (ms_cnt),
    .cycle_counter             (cyc_cnt),
    .ms_strobe                 (ms_strobe),
    .ch_remaining              (ch_remaining),
    .ch_armed                  (ch_armed),
    .irq_pending               (irq_pending),
    .irq_any                   (irq_any)
  );

  // Reference model state
  longint phase_m;
  longint ms_m;
  longint cyc_m;
  bit     strobe_m;
  bit     any_m;
  bit     arm_m  [N];
  bit     per_m  [N];
  bit     pend_m [N];
  longint cmp_m  [N];
  longint dl_m   [N];

  int    errors = 0;
  int    checks = 0;
  string where  = "reset";

  task automatic reset_model();
    phase_m = 0; ms_m = 0; cyc_m = 0; strobe_m = 1'b0; any_m = 1'b0;
    for (int k = 0; k < N; k++) begin
      arm_m[k] = 1'b0; per_m[k] = 1'b0; pend_m[k] = 1'b0; cmp_m[k] = 0; dl_m[k] = 0;
    end
  endtask

  task automatic chk(string item, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: got %0h expected %0h", where, item, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N*W-1:0] rem_e;
    logic [N-1:0]   arm_e;
    logic [N-1:0]   pend_e;
    for (int k = 0; k < N; k++) begin
      rem_e[k*W +: W] = arm_m[k] ? W'(dl_m[k] - ms_m) : '0;
      arm_e[k]        = arm_m[k];
      pend_e[k]       = pend_m[k];
    end
    chk("ms_strobe", 128'(ms_strobe), 128'(strobe_m));
    chk("ms_counter", 128'(ms_cnt), 128'(W'(ms_m)));
    chk("cycle_counter", 128'(cyc_cnt), 128'(W'(cyc_m)));
    chk("ch_remaining", 128'(ch_remaining), 128'(rem_e));
    chk("ch_armed", 128'(ch_armed), 128'(arm_e));
    chk("irq_pending", 128'(irq_pending), 128'(pend_e));
    chk("irq_any", 128'(irq_any), 128'(any_m));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(bit we, int ch, int unsigned cmp, bit per, bit [N-1:0] ack);
    bit tick;
    bit any_prev;
    wr_en = we; wr_ch = ch[1:0]; wr_compare = cmp; wr_periodic = per; irq_ack = ack;
    @(posedge clk_sys);
    tick = (phase_m >= longint'(freq));
    any_prev = 1'b0;
    for (int k = 0; k < N; k++) any_prev |= pend_m[k];
    if (tick) begin
      ms_m++;
      phase_m = 0;
    end else begin
      phase_m++;
    end
    cyc_m++;
    strobe_m = tick;
    any_m    = any_prev;
    for (int k = 0; k < N; k++) begin
      if (we && ch == k) begin
        arm_m[k]  = (cmp != 0);
        per_m[k]  = per;
        cmp_m[k]  = cmp;
        dl_m[k]   = ms_m + cmp;
        pend_m[k] = 1'b0;
      end else if (tick && arm_m[k] && ms_m == dl_m[k]) begin
        pend_m[k] = 1'b1;
        if (per_m[k]) dl_m[k] += cmp_m[k];
        else          arm_m[k] = 1'b0;
      end else if (ack[k]) begin
        pend_m[k] = 1'b0;
      end
    end
    #1;
    check_all();
    wr_en = 1'b0; irq_ack = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; freq = 32'd4; wr_en = 1'b0; wr_ch = 2'd0; wr_compare = '0;
    wr_periodic = 1'b0; irq_ack = '0;
    reset_model();
    #2;
    check_all();
    #10 rst = 1'b0;

    // Periodic channel 0, compare 3, with an ack between fires
    where = "periodic";
    step(1'b1, 0, 3, 1'b1, '0);
    idle(14);
    step(1'b0, 0, 0, 1'b0, 3'b001);
    idle(16);

    // One-shot channel 1, compare 2, then no refire over 10+ ticks
    where = "oneshot";
    step(1'b1, 1, 2, 1'b0, '0);
    idle(60);

    // Ack colliding with a fire every cycle keeps pending set
    where = "ack_vs_fire";
    freq = 32'd0;
    step(1'b1, 0, 1, 1'b1, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0, 3'b001);
    freq = 32'd2;
    for (int i = 0; i < 9; i++) step(1'b0, 0, 0, 1'b0, 3'b001);

    // Compare 0 disarms, out-of-range channel index is ignored
    where = "cmp_zero";
    step(1'b1, 0, 0, 1'b1, '0);
    idle(4);
    where = "bad_ch";
    step(1'b1, 3, 2, 1'b1, '0);
    idle(6);

    // Lower the period from 100 to 3 with the prescaler at 50
    where = "freq_drop";
    freq = 32'd100;
    for (int i = 0; i < 300 && phase_m != 50; i++) idle(1);
    freq = 32'd3;
    idle(14);

    // Asynchronous reset mid-count with two channels armed
    where = "mid_reset";
    freq = 32'd2;
    step(1'b1, 0, 4, 1'b1, '0);
    step(1'b1, 1, 6, 1'b0, '0);
    idle(5);
    #3 rst = 1'b1;
    reset_model();
    #1;
    check_all();
    repeat (2) @(posedge clk_sys);
    #1;
    check_all();
    #3 rst = 1'b0;
    where = "after_reset";
    idle(30);

    // Random writes, acks and period changes
    where = "random";
    for (int i = 0; i < 600; i++) begin
      bit [N-1:0] ack_r;
      if ($urandom_range(0, 19) == 0) freq = 32'($urandom_range(0, 6));
      for (int k = 0; k < N; k++) ack_r[k] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
           $urandom_range(0, 5), 1'($urandom_range(0, 1)), ack_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
